// File: rtl/condiciona_entrada.sv
// Input conditioner: synchronizer, debounce FSM with stability counter and edge pulses.
// Optional AUTO_REPEAT_EN macro adds periodic w_rise pulses while the input is held high.
module condiciona_entrada #(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 4,
    parameter int CNT_W         = 3,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic ck,
    input  logic rst,
    input  logic btn,
    input  logic en,
    output logic w,
    output logic w_rise,
    output logic w_fall,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE_LO,
        CHK_HI,
        IDLE_HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || DEB_CYCLES < 1 || DEB_CYCLES > (1 << CNT_W) || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("condiciona_entrada: illegal parameter combination");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

`ifdef AUTO_REPEAT_EN
    localparam int RCNT_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RCNT_W-1:0] REP_LAST = RCNT_W'(REPEAT_CYCLES - 1);
    logic [RCNT_W-1:0] rcnt;
`endif

    // The synchronizer keeps shifting even while en is low.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign busy = (state == CHK_HI) || (state == CHK_LO);

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            w      <= 1'b0;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt   <= '0;
`endif
        end else begin
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            if (en) begin
`ifdef AUTO_REPEAT_EN
                rcnt <= '0;
`endif
                unique case (state)
                    IDLE_LO: begin
                        if (s) begin
                            state <= CHK_HI;
                            cnt   <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!s) begin
                            state <= IDLE_LO;
                        end else if (cnt == CNT_LAST) begin
                            state  <= IDLE_HI;
                            w      <= 1'b1;
                            w_rise <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    IDLE_HI: begin
                        if (!s) begin
                            state <= CHK_LO;
                            cnt   <= '0;
                        end
`ifdef AUTO_REPEAT_EN
                        else if (rcnt == REP_LAST) begin
                            w_rise <= 1'b1;
                            rcnt   <= '0;
                        end else begin
                            rcnt <= rcnt + RCNT_W'(1);
                        end
`endif
                    end
                    CHK_LO: begin
                        if (s) begin
                            state <= IDLE_HI;
                        end else if (cnt == CNT_LAST) begin
                            state  <= IDLE_LO;
                            w      <= 1'b0;
                            w_fall <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE_LO;
                endcase
            end
        end
    end

endmodule
